// File: rtl/score_display_scanner.sv
// score_display_scanner
//   Captures both players' scores on a load strobe, converts each to tens/ones
//   with a sequential subtract-by-10 engine, then time-multiplexes the four
//   digits onto one shared BCD decoder and a 4-anode common display.
//   Digits are double-buffered: the scanned display only changes in COMMIT.
//
//   Optional feature: define SCORE_BLANK_LEADING_ZERO_EN to darken a tens
//   digit of 0 (anodes all high for that slot; o_digit still presents 0).
//
// Ports
//   i_clk       system clock, rising edge
//   i_reset     synchronous active-high reset
//   i_load      one-cycle strobe: capture scores, start conversion
//   i_p1_score  player-1 score (7-bit unsigned, saturated to MAX_SCORE)
//   i_p2_score  player-2 score (7-bit unsigned, saturated to MAX_SCORE)
//   o_busy      conversion in progress; i_load ignored while high
//   o_done      one-cycle pulse when new digits reach the display
//   o_digit     BCD value of the currently scanned digit
//   o_an        active-low one-hot anode enables, o_an[3] = leftmost digit
module score_display_scanner #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned MAX_SCORE   = 99
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [6:0] i_p1_score,
  input  logic [6:0] i_p2_score,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_digit,
  output logic [3:0] o_an
);

  localparam int unsigned     CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       SAT     = 7'(MAX_SCORE);

  typedef enum logic [1:0] {IDLE, CONV_P1, CONV_P2, COMMIT} state_t;

  state_t           state_q, state_d;
  logic [6:0]       rem_q, rem_d;
  logic [6:0]       p2_hold_q, p2_hold_d;
  logic [3:0]       tens_q, tens_d;
  // Digit order in both buffers: [0]=P1 tens, [1]=P1 ones, [2]=P2 tens, [3]=P2 ones
  logic [3:0][3:0]  shadow_q, shadow_d;
  logic [3:0][3:0]  disp_q, disp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       digit_q, digit_d;
  logic [3:0]       an_q, an_d;
  logic             rem_lt10;
  logic             wrap;

  function automatic logic [6:0] sat_score(input logic [6:0] s);
    return (s > SAT) ? SAT : s;
  endfunction

  // Conversion FSM: repeated subtraction of 10, P1 then P2, then commit.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    p2_hold_d = p2_hold_q;
    tens_d    = tens_q;
    shadow_d  = shadow_q;
    disp_d    = disp_q;
    done_d    = 1'b0;
    rem_lt10  = (rem_q < 7'd10);

    unique case (state_q)
      IDLE: begin
        if (i_load) begin
          rem_d     = sat_score(i_p1_score);
          p2_hold_d = sat_score(i_p2_score);
          tens_d    = 4'd0;
          state_d   = CONV_P1;
        end
      end
      CONV_P1: begin
        if (!rem_lt10) begin
          rem_d  = rem_q - 7'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          shadow_d[0] = tens_q;
          shadow_d[1] = rem_q[3:0];
          rem_d       = p2_hold_q;
          tens_d      = 4'd0;
          state_d     = CONV_P2;
        end
      end
      CONV_P2: begin
        if (!rem_lt10) begin
          rem_d  = rem_q - 7'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          shadow_d[2] = tens_q;
          shadow_d[3] = rem_q[3:0];
          state_d     = COMMIT;
        end
      end
      COMMIT: begin
        disp_d  = shadow_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Scanner: free-running refresh counter, digit index steps on wrap.
  // o_digit follows the next display contents so a commit shows up at once;
  // o_an only moves on a slot boundary.
  always_comb begin
    wrap    = (cnt_q == CNT_MAX);
    cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    digit_d = disp_d[idx_d];
    an_d    = an_q;
    if (wrap) begin
      an_d = ~(4'b1000 >> idx_d);
`ifdef SCORE_BLANK_LEADING_ZERO_EN
      if (!idx_d[0] && (disp_d[idx_d] == 4'd0)) begin
        an_d = 4'b1111;
      end
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      p2_hold_q <= '0;
      tens_q    <= '0;
      shadow_q  <= '0;
      disp_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      digit_q   <= 4'd0;
      an_q      <= 4'b0111;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      p2_hold_q <= p2_hold_d;
      tens_q    <= tens_d;
      shadow_q  <= shadow_d;
      disp_q    <= disp_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_digit = digit_q;
  assign o_an    = an_q;

endmodule
